// File: rtl/mdu_div_iter.sv
// Iterative RV32M divide unit (DIV, DIVU, REM, REMU) for the execute stage.
// The quotient is developed one bit per cycle with a radix-2 restoring
// algorithm on operand magnitudes. Signs are applied in a final fix-up cycle.
// Divide-by-zero and signed overflow are answered immediately on accept.
module mdu_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e          state_q;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q, result_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      op_q;
  logic [4:0]      rd_q, rd_out_q;
  logic            neg_quo_q, neg_rem_q, done_q;

  logic            can_accept, accept;
  logic            is_signed, a_neg, b_neg, div_zero, overflow;
  logic [XLEN-1:0] a_mag, b_mag, special_result;
  logic [XLEN:0]   rem_shift, trial;
  logic [XLEN-1:0] rem_d, quo_d;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_result;

  assign can_accept = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept     = start_i && can_accept && !flush_i;

  // Operand decode for a new op: magnitudes, sign flags and the two special cases.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    is_signed      = ~op_i[0];
    a_neg          = is_signed & dividend_i[XLEN-1];
    b_neg          = is_signed & divisor_i[XLEN-1];
    a_mag          = a_neg ? (~dividend_i + 1'b1) : dividend_i;
    b_mag          = b_neg ? (~divisor_i + 1'b1) : divisor_i;
    div_zero       = (divisor_i == '0);
    overflow       = is_signed && (dividend_i == MIN_NEG) && (&divisor_i);
    special_result = '0;
    if (div_zero)      special_result = op_i[1] ? dividend_i : '1;
    else if (overflow) special_result = op_i[1] ? '0 : MIN_NEG;
  end

  // One restoring step: the trial subtract is XLEN+1 bits so the shifted-out
  // remainder bit takes part in the compare.
  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    trial     = rem_shift - {1'b0, dvsr_q};
    rem_d     = trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
    quo_d     = {quo_q[XLEN-2:0], ~trial[XLEN]};
  end

  // Sign fix-up and quotient/remainder selection.
  always_comb begin
    quo_fix    = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix    = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    fix_result = op_q[1] ? rem_fix : quo_fix;
  end

  // Pipeline hold: the accept cycle plus every CALC/FIX cycle, never while flushing.
  assign stall_o  = rst && !flush_i && (accept || state_q == S_CALC || state_q == S_FIX);
  assign busy_o   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign rd_o     = rd_out_q;

  // Control FSM and datapath registers; flush dominates everything.
  // NOTE: sequential state uses non-blocking assignments only; every register,
  // datapath included, is cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      rd_out_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
          if (accept) begin
            op_q      <= op_i;
            rd_q      <= rd_i;
            quo_q     <= a_mag;
            dvsr_q    <= b_mag;
            rem_q     <= '0;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            cnt_q     <= CW'(XLEN);
            if (div_zero || overflow) begin
              result_q <= special_result;
              rd_out_q <= rd_i;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          result_q <= fix_result;
          rd_out_q <= rd_q;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_div_iter.sv
// Directed bench for mdu_div_iter: hand-computed vectors, latency and stall
// counts, flush, back-to-back issue, mid-op reset, and a short random run
// checked against a behavioural reference.
module tb_mdu_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = '0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [4:0]  rd_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;

  mdu_div_iter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .rd_i(rd_i),
    .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .rd_o(rd_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
    case (op)
      DIV:     return sa / sb;
      DIVU:    return a / b;
      REM:     return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // Called right after a posedge with start_i already driven. Counts stall
  // cycles and edges (accept edge = 1) until done_o; operands are scrambled
  // after accept to show they are not re-sampled.
  task automatic wait_done(output int lat, output int stl);
    lat = 0;
    stl = 0;
    do begin
      @(negedge clk);
      if (stall_o) stl++;
      @(posedge clk);
      #1;
      start_i    = 1'b0;
      dividend_i = $urandom;
      divisor_i  = $urandom;
      lat++;
    end while (!done_o && lat < 200);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    start_i    = 1'b1;
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    rd_i       = rd;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int lat, stl;
    issue(op, a, b, rd);
    wait_done(lat, stl);
    check({tag, " result"}, result_o, exp);
    check({tag, " rd"}, 32'(rd_o), 32'(rd));
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " stall cycles"}, 32'(stl), 32'(exp_lat));
    @(posedge clk);
    #1;
    check({tag, " pulse"}, 32'(done_o), 32'd0);
    check({tag, " hold"}, result_o, exp);
  endtask

  // Start an op, flush it k edges after accept, and check it dies quietly.
  task automatic flush_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int k);
    issue(op, a, b, rd);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (k - 1) begin
      @(posedge clk);
      #1;
    end
    flush_i = 1'b1;
    #1;
    check({tag, " stall in flush"}, 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check({tag, " busy after flush"}, 32'(busy_o), 32'd0);
    check({tag, " done after flush"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    int lat, stl, quiet;
    logic [4:0]  rd_before;
    logic [31:0] res_before;
    logic [31:0] corner [6];
    logic [31:0] a, b;
    logic [1:0]  op;

    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0001};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset stall", 32'(stall_o), 32'd0);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset done", 32'(done_o), 32'd0);
    check("reset result", result_o, 32'd0);
    check("reset rd", 32'(rd_o), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Normal ops.
    run_op("DIV 100/7", DIV, 32'd100, 32'd7, 5'd5, 32'd14, 34);
    run_op("REM -100/7", REM, 32'hFFFF_FF9C, 32'd7, 5'd6, 32'hFFFF_FFFE, 34);
    run_op("DIV -100/7", DIV, 32'hFFFF_FF9C, 32'd7, 5'd7, 32'hFFFF_FFF2, 34);
    run_op("REMU ffffffff/16", REMU, 32'hFFFF_FFFF, 32'd16, 5'd8, 32'd15, 34);
    run_op("REMU wide trial", REMU, 32'hFFFF_FFFF, 32'h8000_0001, 5'd9, 32'h7FFF_FFFE, 34);
    run_op("DIVU wide trial", DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 5'd10, 32'd1, 34);

    // Special cases.
    run_op("DIVU 123/0", DIVU, 32'd123, 32'd0, 5'd11, 32'hFFFF_FFFF, 1);
    run_op("REM 123/0", REM, 32'd123, 32'd0, 5'd12, 32'd123, 1);
    run_op("DIV ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
    run_op("REM ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0, 1);

    // Flush at CALC cycle 10: no done, rd_o and result_o untouched.
    rd_before  = rd_o;
    res_before = result_o;
    flush_op("flush", DIV, 32'd1000, 32'd3, 5'd20, 11);
    quiet = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_o) quiet++;
    end
    check("flush no late done", 32'(quiet), 32'd0);
    check("flush rd kept", 32'(rd_o), 32'(rd_before));
    check("flush result kept", result_o, res_before);
    run_op("DIV 9/3", DIV, 32'd9, 32'd3, 5'd21, 32'd3, 34);

    // Back-to-back: op B is issued during the DONE cycle of op A.
    issue(DIV, 32'd100, 32'd7, 5'd1);
    wait_done(lat, stl);
    check("b2b A result", result_o, 32'd14);
    check("b2b A rd", 32'(rd_o), 32'd1);
    issue(DIVU, 32'd50, 32'd5, 5'd2);
    wait_done(lat, stl);
    check("b2b B latency", 32'(lat), 32'd34);
    check("b2b B stall cycles", 32'(stl), 32'd34);
    check("b2b B result", result_o, 32'd10);
    check("b2b B rd", 32'(rd_o), 32'd2);
    @(posedge clk);
    #1;
    check("b2b B pulse", 32'(done_o), 32'd0);

    // Reset mid-CALC.
    issue(DIV, 32'd77, 32'd5, 5'd3);
    repeat (6) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
    end
    rst = 1'b0;
    #1;
    check("midrst stall", 32'(stall_o), 32'd0);
    check("midrst busy", 32'(busy_o), 32'd0);
    check("midrst done", 32'(done_o), 32'd0);
    check("midrst result", result_o, 32'd0);
    check("midrst rd", 32'(rd_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_op("REMU 100/7 after rst", REMU, 32'd100, 32'd7, 5'd4, 32'd2, 34);

    // Short random run against the reference, with occasional flushes.
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0 && b != 0 && !(op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
        flush_op("rand flush", op, a, b, 5'(i), $urandom_range(1, 30));
      end else begin
        issue(op, a, b, 5'(i));
        wait_done(lat, stl);
        check($sformatf("rand op%0d %08h/%08h", op, a, b), result_o, ref_div(op, a, b));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
